// File: rtl/fir_line_sequencer.sv
// fir_line_sequencer
// Sequences the U/V chroma interpolation FIR for one frame: issues the SRAM
// read addresses for U and V words, drives the FIR line/enable/load controls
// and flags each completed U'/V' odd-pixel pair for the RGB stage.
//
// Ports:
//   CLOCK_50_I    in   clock
//   reset         in   asynchronous active-high reset
//   start         in   one-cycle frame start pulse (accepted only when idle)
//   busy          out  frame in progress
//   done          out  one-cycle pulse after the last line
//   SRAM_address  out  18-bit read address, valid while sram_rd is high
//   sram_rd       out  sequencer owns the SRAM this cycle
//   line_start, line_end, enable_U, enable_V, load_U_buffer, load_V_buffer,
//   read_U_0, read_V_0, cycle   out  FIR controls
//   pair_valid    out  FIR_BUFF_U/V hold a fresh pair
//   pixel_pair    out  index of the pair flagged by pair_valid
//   line_count    out  current line
module fir_line_sequencer #(
    parameter int unsigned U_BASE       = 38400,
    parameter int unsigned V_BASE       = 57600,
    parameter int unsigned LINE_WORDS   = 80,
    parameter int unsigned NUM_LINES    = 240,
    parameter int unsigned SRAM_LATENCY = 2
) (
    input  logic        CLOCK_50_I,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [17:0] SRAM_address,
    output logic        sram_rd,
    output logic        line_start,
    output logic        line_end,
    output logic        enable_U,
    output logic        enable_V,
    output logic        load_U_buffer,
    output logic        load_V_buffer,
    output logic        read_U_0,
    output logic        read_V_0,
    output logic        cycle,
    output logic        pair_valid,
    output logic [7:0]  pixel_pair,
    output logic [7:0]  line_count
);

    localparam int unsigned ADDR_W          = 18;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned SLOTS           = 2 * LINE_WORDS;
    localparam int unsigned PHASES          = 6;
    localparam int unsigned PRO_LEN         = 8;
    localparam int unsigned PRO_ISSUES      = 6;
    localparam int unsigned LAST_ISSUE_SLOT = SLOTS - 7;
    localparam int unsigned EDGE_SLOT       = SLOTS - 4;
    localparam int unsigned PLANE_WORDS     = LINE_WORDS * NUM_LINES;
    localparam int unsigned ADDR_SPACE      = 32'd1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PROLOGUE = 2'd1,
        S_COMMON   = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    // Tag kinds carried through the SRAM latency pipeline
    localparam logic [1:0] K_READ0  = 2'd0;
    localparam logic [1:0] K_ENABLE = 2'd1;
    localparam logic [1:0] K_LOAD   = 2'd2;

    state_t              state_q, state_d;
    logic [2:0]          pcnt_q, pcnt_d;
    logic [2:0]          phase_q, phase_d;
    logic [CNT_W-1:0]    slot_q, slot_d;
    logic [CNT_W-1:0]    line_q, line_d;
    logic [ADDR_W-1:0]   lbase_q, lbase_d;

    logic                tag0_vld_q, tag0_v_q, tag1_vld_q, tag1_v_q;
    logic [1:0]          tag0_kind_q, tag1_kind_q;
    logic                tag_vld_d, tag_v_d;
    logic [1:0]          tag_kind_d;

    logic [ADDR_W-1:0]   word_off;
    logic [ADDR_W-1:0]   addr_d;
    logic                busy_d, done_d, rd_d, ls_d, le_d, en_u_d, en_v_d;
    logic                ld_u_d, ld_v_d, rd_u0_d, rd_v0_d, cycle_d, pv_d;
    logic [CNT_W-1:0]    pp_d;

    // State, position counters and tag pipeline
    always_ff @(posedge CLOCK_50_I or posedge reset) begin : state_reg
        if (reset) begin
            state_q     <= S_IDLE;
            pcnt_q      <= '0;
            phase_q     <= '0;
            slot_q      <= '0;
            line_q      <= '0;
            lbase_q     <= '0;
            tag0_vld_q  <= 1'b0;
            tag0_v_q    <= 1'b0;
            tag0_kind_q <= '0;
            tag1_vld_q  <= 1'b0;
            tag1_v_q    <= 1'b0;
            tag1_kind_q <= '0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            phase_q     <= phase_d;
            slot_q      <= slot_d;
            line_q      <= line_d;
            lbase_q     <= lbase_d;
            tag0_vld_q  <= tag_vld_d;
            tag0_v_q    <= tag_v_d;
            tag0_kind_q <= tag_kind_d;
            tag1_vld_q  <= tag0_vld_q;
            tag1_v_q    <= tag0_v_q;
            tag1_kind_q <= tag0_kind_q;
        end
    end

    // Next position plus output decode; outputs are decoded from the next
    // position so the registered outputs line up with the position counters.
    always_comb begin : fsm_comb
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        phase_d    = phase_q;
        slot_d     = slot_q;
        line_d     = line_q;
        lbase_d    = lbase_q;
        tag_vld_d  = 1'b0;
        tag_v_d    = 1'b0;
        tag_kind_d = K_READ0;
        word_off   = '0;
        addr_d     = '0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        rd_d       = 1'b0;
        ls_d       = 1'b0;
        le_d       = 1'b0;
        en_u_d     = 1'b0;
        en_v_d     = 1'b0;
        ld_u_d     = 1'b0;
        ld_v_d     = 1'b0;
        rd_u0_d    = 1'b0;
        rd_v0_d    = 1'b0;
        cycle_d    = 1'b0;
        pv_d       = 1'b0;
        pp_d       = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PROLOGUE;
                    pcnt_d  = '0;
                    line_d  = '0;
                    lbase_d = '0;
                end
            end
            S_PROLOGUE: begin
                if (pcnt_q == 3'(PRO_LEN - 1)) begin
                    state_d = S_COMMON;
                    phase_d = '0;
                    slot_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + 3'd1;
                end
            end
            S_COMMON: begin
                if (phase_q == 3'(PHASES - 1)) begin
                    phase_d = '0;
                    if (slot_q == CNT_W'(SLOTS - 1)) begin
                        if (line_q < CNT_W'(NUM_LINES - 1)) begin
                            state_d = S_PROLOGUE;
                            pcnt_d  = '0;
                            line_d  = line_q + CNT_W'(1);
                            lbase_d = lbase_q + ADDR_W'(LINE_WORDS);
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        slot_d = slot_q + CNT_W'(1);
                    end
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);

        case (state_d)
            S_PROLOGUE: begin
                ls_d = 1'b1;
                // Alternating U/V issues; pcnt[2:1] is both word offset and tag kind
                if (pcnt_d <= 3'(PRO_ISSUES - 1)) begin
                    rd_d       = 1'b1;
                    tag_vld_d  = 1'b1;
                    tag_v_d    = pcnt_d[0];
                    tag_kind_d = pcnt_d[2:1];
                    word_off   = ADDR_W'(pcnt_d[2:1]);
                end
            end
            S_COMMON: begin
                en_u_d  = (phase_d == 3'd0);
                en_v_d  = (phase_d == 3'd3);
                cycle_d = slot_d[0];
                le_d    = (slot_d >= CNT_W'(EDGE_SLOT));
                if (slot_d[0] && (slot_d <= CNT_W'(LAST_ISSUE_SLOT)) &&
                    ((phase_d == 3'd1) || (phase_d == 3'd4))) begin
                    rd_d       = 1'b1;
                    tag_vld_d  = 1'b1;
                    tag_v_d    = (phase_d == 3'd4);
                    tag_kind_d = K_LOAD;
                    word_off   = (ADDR_W'(slot_d) + ADDR_W'(5)) >> 1;
                end
            end
            default: ;
        endcase

        if (rd_d) begin
            addr_d = (tag_v_d ? ADDR_W'(V_BASE) : ADDR_W'(U_BASE)) + lbase_d + word_off;
        end

        // Returning read: tag1 holds the issue from SRAM_LATENCY cycles before the next cycle
        if (tag1_vld_q) begin
            case (tag1_kind_q)
                K_READ0: begin
                    rd_u0_d = ~tag1_v_q;
                    rd_v0_d = tag1_v_q;
                end
                K_ENABLE: begin
                    en_u_d = en_u_d | ~tag1_v_q;
                    en_v_d = en_v_d | tag1_v_q;
                end
                K_LOAD: begin
                    ld_u_d = ~tag1_v_q;
                    ld_v_d = tag1_v_q;
                end
                default: ;
            endcase
        end

        // Pair for slot s is complete once its last phase has run
        if ((state_q == S_COMMON) && (phase_q == 3'(PHASES - 1))) begin
            pv_d = 1'b1;
            pp_d = slot_q;
        end
    end

    // Registered outputs
    always_ff @(posedge CLOCK_50_I or posedge reset) begin : out_reg
        if (reset) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            SRAM_address  <= '0;
            sram_rd       <= 1'b0;
            line_start    <= 1'b0;
            line_end      <= 1'b0;
            enable_U      <= 1'b0;
            enable_V      <= 1'b0;
            load_U_buffer <= 1'b0;
            load_V_buffer <= 1'b0;
            read_U_0      <= 1'b0;
            read_V_0      <= 1'b0;
            cycle         <= 1'b0;
            pair_valid    <= 1'b0;
            pixel_pair    <= '0;
        end else begin
            busy          <= busy_d;
            done          <= done_d;
            SRAM_address  <= addr_d;
            sram_rd       <= rd_d;
            line_start    <= ls_d;
            line_end      <= le_d;
            enable_U      <= en_u_d;
            enable_V      <= en_v_d;
            load_U_buffer <= ld_u_d;
            load_V_buffer <= ld_v_d;
            read_U_0      <= rd_u0_d;
            read_V_0      <= rd_v0_d;
            cycle         <= cycle_d;
            pair_valid    <= pv_d;
            pixel_pair    <= pp_d;
        end
    end

    assign line_count = line_q;

    // Configuration sanity: both planes fit the 18-bit space, fixed latency
    always_ff @(posedge CLOCK_50_I) begin : cfg_check
        assert ((U_BASE + PLANE_WORDS <= ADDR_SPACE) && (V_BASE + PLANE_WORDS <= ADDR_SPACE) &&
                (LINE_WORDS >= 4) && (SRAM_LATENCY == 2))
            else $error("fir_line_sequencer: bad configuration");
    end

endmodule
